// File: rtl/pe_ctrl_if.sv
// Handshake, command and PE-strobe bundle between a job source/PE datapath and pe_ctrl.
// The master side is the controller, the slave side is the environment.
interface pe_ctrl_if #(
  parameter int unsigned TAP_W = 4
);
  logic             start;
  logic [TAP_W-1:0] num_taps;
  logic             pool_mode;
  logic             bias_en;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       pe_resp;

  logic             if_rf_wr_en;
  logic             wt_rf_wr_en;
  logic             mult_load;
  logic             mult_en;
  logic             add_en_1;
  logic             add_en_2;
  logic             acc_wr_en;
  logic             acc_clr;
  logic             of_rf_wr_en;

  logic             actn_in_sel;
  logic             wt_in_sel;
  logic             add_in_sel;
  logic             pe_out_sel;

  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, num_taps, pool_mode, bias_en, op_valid, pe_resp,
    output op_ready, if_rf_wr_en, wt_rf_wr_en, mult_load, mult_en, add_en_1,
           add_en_2, acc_wr_en, acc_clr, of_rf_wr_en, actn_in_sel, wt_in_sel,
           add_in_sel, pe_out_sel, busy, done, err
  );

  modport slave (
    output start, num_taps, pool_mode, bias_en, op_valid, pe_resp,
    input  op_ready, if_rf_wr_en, wt_rf_wr_en, mult_load, mult_en, add_en_1,
           add_en_2, acc_wr_en, acc_clr, of_rf_wr_en, actn_in_sel, wt_in_sel,
           add_in_sel, pe_out_sel, busy, done, err
  );
endinterface

// File: rtl/pe_ctrl.sv
// Sequencer for one processing element: runs a conv MAC or max-pool job per start,
// issuing PE strobes/selects and guarding every PE wait state with a watchdog.
module pe_ctrl #(
  parameter int unsigned TAP_W = 4,
  parameter int unsigned TMO   = 64
) (
  input logic       clk,
  input logic       rst,
  pe_ctrl_if.master bus
);

  localparam int unsigned   WD_W    = $clog2(TMO + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LOAD, S_MLD, S_MULT, S_ADD, S_ACC,
    S_POOL, S_BLOAD, S_BADD, S_BACC, S_FIN, S_WR, S_DONE
  } state_t;

  typedef struct packed {
    logic op_ready;
    logic mult_load;
    logic mult_en;
    logic add_en_1;
    logic add_en_2;
    logic acc_wr_en;
    logic acc_clr;
    logic of_rf_wr_en;
    logic actn_in_sel;
    logic wt_in_sel;
    logic add_in_sel;
    logic pe_out_sel;
    logic busy;
    logic done;
    logic err;
  } ctl_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             pool_q, pool_d;
  logic             bias_q, bias_d;
  ctl_t             ctl_q, ctl_d;

  logic xfer;
  logic wait_st;
  logic tmo_hit;
  logic last_tap;

  // op_ready is high only in LOAD/BLOAD, so this is the operand transfer itself
  assign xfer     = ctl_q.op_ready & bus.op_valid;
  assign wait_st  = (state_q == S_MULT) || (state_q == S_ADD) ||
                    (state_q == S_BADD) || (state_q == S_FIN);
  assign tmo_hit  = (wd_q == WD_LAST);
  assign last_tap = (tap_q == TAP_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      wd_q    <= '0;
      pool_q  <= 1'b0;
      bias_q  <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      wd_q    <= wd_d;
      pool_q  <= pool_d;
      bias_q  <= bias_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    wd_d    = wd_q;
    pool_d  = pool_q;
    bias_d  = bias_q;
    ctl_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_taps != '0) begin
            state_d = S_CLR;
            tap_d   = bus.num_taps;
            pool_d  = bus.pool_mode;
            bias_d  = bus.bias_en;
          end else begin
            ctl_d.err = 1'b1;
          end
        end
      end
      S_CLR:  state_d = S_LOAD;
      S_LOAD: begin
        if (xfer) state_d = pool_q ? S_POOL : S_MLD;
      end
      S_MLD:  state_d = S_MULT;
      S_MULT: begin
        if (bus.pe_resp[0]) begin
          state_d = S_ADD;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          ctl_d.err = 1'b1;
        end
      end
      S_ADD: begin
        if (bus.pe_resp[1]) begin
          state_d = S_ACC;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          ctl_d.err = 1'b1;
        end
      end
      S_ACC: begin
        tap_d = tap_q - TAP_W'(1);
        if (last_tap) state_d = bias_q ? S_BLOAD : S_FIN;
        else          state_d = S_LOAD;
      end
      S_POOL: begin
        tap_d   = tap_q - TAP_W'(1);
        state_d = last_tap ? S_FIN : S_LOAD;
      end
      S_BLOAD: begin
        if (xfer) state_d = S_BADD;
      end
      S_BADD: begin
        if (bus.pe_resp[1]) begin
          state_d = S_BACC;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          ctl_d.err = 1'b1;
        end
      end
      S_BACC: state_d = S_FIN;
      S_FIN: begin
        if (bus.pe_resp[2]) begin
          state_d = S_WR;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          ctl_d.err = 1'b1;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change and counts only while waiting on the PE
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wait_st) begin
      wd_d = wd_q + WD_W'(1);
    end

    // Outputs decoded from the state being entered, so they are registered yet aligned to it
    unique case (state_d)
      S_CLR:   ctl_d.acc_clr     = 1'b1;
      S_LOAD:  ctl_d.op_ready    = 1'b1;
      S_BLOAD: ctl_d.op_ready    = 1'b1;
      S_MLD:   ctl_d.mult_load   = 1'b1;
      S_MULT:  ctl_d.mult_en     = 1'b1;
      S_ADD:   ctl_d.add_en_1    = 1'b1;
      S_ACC:   ctl_d.acc_wr_en   = 1'b1;
      S_BACC:  ctl_d.acc_wr_en   = 1'b1;
      S_BADD: begin
        ctl_d.add_en_1   = 1'b1;
        ctl_d.add_in_sel = 1'b1;
      end
      S_FIN:   ctl_d.add_en_2    = 1'b1;
      S_WR:    ctl_d.of_rf_wr_en = 1'b1;
      S_DONE:  ctl_d.done        = 1'b1;
      default: ;
    endcase

    // Path selects follow the captured job type and stay put for the whole job
    if (state_d != S_IDLE) begin
      ctl_d.busy        = 1'b1;
      ctl_d.actn_in_sel = ~pool_d;
      ctl_d.pe_out_sel  = pool_d;
      ctl_d.wt_in_sel   = (state_d != S_BADD);
    end
  end

  assign bus.op_ready    = ctl_q.op_ready;
  assign bus.if_rf_wr_en = xfer & (state_q == S_LOAD);
  assign bus.wt_rf_wr_en = xfer;
  assign bus.mult_load   = ctl_q.mult_load;
  assign bus.mult_en     = ctl_q.mult_en;
  assign bus.add_en_1    = ctl_q.add_en_1;
  assign bus.add_en_2    = ctl_q.add_en_2;
  assign bus.acc_wr_en   = ctl_q.acc_wr_en;
  assign bus.acc_clr     = ctl_q.acc_clr;
  assign bus.of_rf_wr_en = ctl_q.of_rf_wr_en;
  assign bus.actn_in_sel = ctl_q.actn_in_sel;
  assign bus.wt_in_sel   = ctl_q.wt_in_sel;
  assign bus.add_in_sel  = ctl_q.add_in_sel;
  assign bus.pe_out_sel  = ctl_q.pe_out_sel;
  assign bus.busy        = ctl_q.busy;
  assign bus.done        = ctl_q.done;
  assign bus.err         = ctl_q.err;

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl: directed jobs push an expected job summary; a monitor tallies the
// strobes of each job and compares on every done/err pulse.
module tb_pe_ctrl;

  localparam int unsigned TAP_W = 4;
  localparam int unsigned TMO   = 24;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct packed {
    int kind; int xf; int ifw; int wto; int acc; int fin; int ofw; int mult;
    int add;  int peo; int actn; int badd; int selbad; int busy; int gap; int lat;
  } rec_t;

  logic clk;
  logic rst;
  logic [2:0] stray;
  logic [2:0] mute;
  logic [16:0] outs;

  int vectors     = 0;
  int miscompares = 0;
  int ends        = 0;
  rec_t exp_q[$];

  pe_ctrl_if #(.TAP_W(TAP_W)) bus ();

  pe_ctrl #(.TAP_W(TAP_W), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {bus.op_ready, bus.if_rf_wr_en, bus.wt_rf_wr_en, bus.mult_load,
                 bus.mult_en, bus.add_en_1, bus.add_en_2, bus.acc_wr_en, bus.acc_clr,
                 bus.of_rf_wr_en, bus.actn_in_sel, bus.wt_in_sel, bus.add_in_sel,
                 bus.pe_out_sel, bus.busy, bus.done, bus.err};

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input int kind, input int xf, input int ifw, input int wto,
                              input int acc, input int fin, input int ofw, input int mult,
                              input int add, input int peo, input int actn, input int badd,
                              input int busy, input int gap, input int lat);
    rec_t r;
    r = '0;
    r.kind = kind; r.xf = xf; r.ifw = ifw; r.wto = wto; r.acc = acc; r.fin = fin;
    r.ofw = ofw; r.mult = mult; r.add = add; r.peo = peo; r.actn = actn; r.badd = badd;
    r.selbad = 0; r.busy = busy; r.gap = gap; r.lat = lat;
    return r;
  endfunction

  task automatic cmp(input rec_t a, input rec_t e, input int jn);
    chk($sformatf("j%0d_kind", jn),   a.kind,   e.kind);
    chk($sformatf("j%0d_xfers", jn),  a.xf,     e.xf);
    chk($sformatf("j%0d_if_wr", jn),  a.ifw,    e.ifw);
    chk($sformatf("j%0d_wt_only", jn), a.wto,   e.wto);
    chk($sformatf("j%0d_acc_wr", jn), a.acc,    e.acc);
    chk($sformatf("j%0d_fin_ph", jn), a.fin,    e.fin);
    chk($sformatf("j%0d_of_wr", jn),  a.ofw,    e.ofw);
    chk($sformatf("j%0d_mult", jn),   a.mult,   e.mult);
    chk($sformatf("j%0d_add1", jn),   a.add,    e.add);
    chk($sformatf("j%0d_pe_out", jn), a.peo,    e.peo);
    chk($sformatf("j%0d_actn", jn),   a.actn,   e.actn);
    chk($sformatf("j%0d_badd", jn),   a.badd,   e.badd);
    chk($sformatf("j%0d_selbad", jn), a.selbad, e.selbad);
    chk($sformatf("j%0d_busy", jn),   a.busy,   e.busy);
    chk($sformatf("j%0d_gap", jn),    a.gap,    e.gap);
    chk($sformatf("j%0d_lat", jn),    a.lat,    e.lat);
  endtask

  // PE model: raises the matching done bit in the 4th cycle an enable is held
  initial begin
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    bus.pe_resp = '0;
    forever begin
      @(posedge clk);
      #1;
      c0 = bus.mult_en  ? c0 + 1 : 0;
      c1 = bus.add_en_1 ? c1 + 1 : 0;
      c2 = bus.add_en_2 ? c2 + 1 : 0;
      bus.pe_resp = {(c2 == 4) & ~mute[2], (c1 == 4) & ~mute[1], (c0 == 4) & ~mute[0]} | stray;
    end
  end

  // Monitor: accumulate one job's activity, check it on done/err
  initial begin
    rec_t a;
    int cyc, of_cyc, mrise, jn;
    logic pa2, pm;
    a = '0; cyc = 0; of_cyc = 0; mrise = 0; jn = 0; pa2 = 1'b0; pm = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        a = '0; pa2 = 1'b0; pm = 1'b0;
      end else begin
        if (bus.busy) a.busy = 1;
        if (bus.op_valid && bus.op_ready) a.xf += 1;
        if (bus.if_rf_wr_en) a.ifw += 1;
        if (bus.wt_rf_wr_en && !bus.if_rf_wr_en) a.wto += 1;
        if (bus.acc_wr_en) a.acc += 1;
        if (bus.add_en_2 && !pa2) a.fin += 1;
        if (bus.of_rf_wr_en) begin a.ofw += 1; of_cyc = cyc; end
        if (bus.mult_en) begin a.mult = 1; if (!pm) mrise = cyc; end
        if (bus.add_en_1) a.add = 1;
        if (bus.pe_out_sel) a.peo = 1;
        if (bus.actn_in_sel) a.actn = 1;
        if (bus.add_en_1 && bus.add_in_sel && !bus.wt_in_sel) a.badd += 1;
        if (bus.busy && (bus.add_in_sel == bus.wt_in_sel)) a.selbad += 1;
        pa2 = bus.add_en_2;
        pm  = bus.mult_en;
        if (bus.done || bus.err) begin
          a.kind = bus.done ? K_DONE : K_ERR;
          a.gap  = bus.done ? cyc - of_cyc : 0;
          a.lat  = (bus.err && a.mult != 0) ? cyc - mrise : 0;
          jn++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL j%0d_unexpected_end: got kind %0d, required no job end", jn, a.kind);
          end else begin
            cmp(a, exp_q.pop_front(), jn);
          end
          ends++;
          a = '0; pa2 = 1'b0; pm = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int taps, input logic pool, input logic bias);
    tick();
    bus.start     = 1'b1;
    bus.num_taps  = TAP_W'(taps);
    bus.pool_mode = pool;
    bus.bias_en   = bias;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int e0);
    int n;
    n = 0;
    while (ends == e0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_job_ended"}, int'(ends != e0), 1);
  endtask

  initial begin
    int e0, n, held;
    rst = 1'b1;
    bus.start = 1'b0; bus.num_taps = '0; bus.pool_mode = 1'b0; bus.bias_en = 1'b0;
    bus.op_valid = 1'b1;
    stray = '0;
    mute  = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    tick();
    rst = 1'b0;

    // conv 3 taps, no bias, with a stray start/config change mid-job
    exp_q.push_back(mk(K_DONE, 3, 3, 0, 3, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0));
    e0 = ends;
    launch(3, 1'b0, 1'b0);
    tick();
    bus.start = 1'b1; bus.num_taps = TAP_W'(7); bus.pool_mode = 1'b1; bus.bias_en = 1'b1;
    tick();
    bus.start = 1'b0; bus.num_taps = '0; bus.pool_mode = 1'b0; bus.bias_en = 1'b0;
    wait_end("conv3", e0);

    // conv 2 taps with bias
    exp_q.push_back(mk(K_DONE, 3, 2, 1, 3, 1, 1, 1, 1, 0, 1, 4, 1, 1, 0));
    e0 = ends;
    launch(2, 1'b0, 1'b1);
    wait_end("conv2b", e0);

    // pool 4 taps
    exp_q.push_back(mk(K_DONE, 4, 4, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0));
    e0 = ends;
    launch(4, 1'b1, 1'b0);
    wait_end("pool4", e0);

    // zero taps: immediate err, never busy
    exp_q.push_back(mk(K_ERR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    e0 = ends;
    launch(0, 1'b0, 1'b0);
    wait_end("zero", e0);

    // multiply never completes: watchdog err TMO cycles after MULT entry
    mute = 3'b001;
    exp_q.push_back(mk(K_ERR, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, int'(TMO)));
    e0 = ends;
    launch(2, 1'b0, 1'b0);
    wait_end("tmo", e0);
    @(negedge clk);
    chk("tmo_idle_busy", int'(bus.busy), 0);
    mute = '0;

    // reset in the middle of ADD aborts the job
    e0 = ends;
    launch(2, 1'b0, 1'b0);
    n = 0;
    while (!bus.add_en_1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_add_reached", int'(bus.add_en_1), 1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rstmid_outs", int'(outs), 0);
    tick();
    rst = 1'b0;
    chk("rstmid_no_end", ends - e0, 0);

    // fresh job after reset
    exp_q.push_back(mk(K_DONE, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0));
    e0 = ends;
    launch(1, 1'b0, 1'b0);
    wait_end("conv1", e0);

    // operands withheld in LOAD with stray PE flags: no timeout, ready held
    exp_q.push_back(mk(K_DONE, 2, 2, 0, 2, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0));
    bus.op_valid = 1'b0;
    stray = 3'b111;
    e0 = ends;
    launch(2, 1'b0, 1'b0);
    n = 0;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.op_ready && !bus.err && bus.busy) held++;
      @(negedge clk);
    end
    chk("hold_ready_cycles", held, 10);
    tick();
    stray = '0;
    bus.op_valid = 1'b1;
    wait_end("hold", e0);

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 Parameters: TAP_W, default 4, width of tap counter; TMO, default 64, wait-state watchdog limit in cycles.
REQ-002 clk  in  1  sole clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  launch one output-pixel job; sampled only in IDLE.
REQ-005 num_taps  in  TAP_W  operand pairs per job; captured on accepted start.
REQ-006 pool_mode  in  1  0 = conv MAC job, 1 = max-pool job; captured on accepted start.
REQ-007 bias_en  in  1  1 = add bias after last tap (conv only); captured on accepted start.
REQ-008 op_valid / op_ready  in / out  1 / 1  operand-pair handshake; transfer when both high.
REQ-009 pe_resp  in  3  PE done flags: [0] multiply, [1] accumulate add, [2] final add.
REQ-010 if_rf_wr_en, wt_rf_wr_en, mult_load, mult_en, add_en_1, add_en_2, acc_wr_en, acc_clr, of_rf_wr_en  out  1 each  PE strobes.
REQ-011 actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel  out  1 each  PE path selects.
REQ-012 busy, done, err  out  1 each  status; done and err are single-cycle pulses.

Function
REQ-013 States: IDLE, CLR, LOAD, MLD, MULT, ADD, ACC, POOL, BLOAD, BADD, BACC, FIN, WR, DONE.
REQ-014 IDLE: start=1 with num_taps!=0 -> CLR, capture config, tap_cnt=num_taps; start with num_taps=0 -> err pulse, stay IDLE.
REQ-015 CLR: acc_clr=1 one cycle -> LOAD.
REQ-016 LOAD: op_ready=1; on transfer if_rf_wr_en=wt_rf_wr_en=1 same cycle; -> MLD (conv) or POOL (pool); no transfer -> stay, no timeout.
REQ-017 MLD: mult_load=1 one cycle -> MULT.
REQ-018 MULT: mult_en=1 held until pe_resp[0]=1 sampled, then -> ADD.
REQ-019 ADD: add_en_1=1, add_in_sel=0, held until pe_resp[1]=1, then -> ACC.
REQ-020 ACC: acc_wr_en=1 one cycle, tap_cnt-1; tap_cnt reaching 0 -> BLOAD if bias_en else FIN; otherwise -> LOAD.
REQ-021 POOL: one cycle, tap_cnt-1; 0 -> FIN else LOAD.
REQ-022 BLOAD: op_ready=1; on transfer only wt_rf_wr_en=1 (bias word) -> BADD.
REQ-023 BADD: add_en_1=1, add_in_sel=1, wt_in_sel=0 until pe_resp[1] -> BACC; BACC: acc_wr_en=1 one cycle -> FIN.
REQ-024 FIN: add_en_2=1 until pe_resp[2] -> WR; WR: of_rf_wr_en=1 one cycle -> DONE; DONE: done=1 one cycle -> IDLE.
REQ-025 Selects: actn_in_sel=~pool_cfg; wt_in_sel=1 except BADD; pe_out_sel=pool_cfg; add_in_sel=0 except BADD; held stable throughout a job.
REQ-026 All strobes not listed for a state SHALL be 0; op_ready=0 outside LOAD/BLOAD.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Watchdog: in MULT, ADD, BADD, FIN, counter increments each cycle; reaching TMO without the awaited pe_resp bit -> err pulse, all strobes 0, -> IDLE; counter clears on each state entry.
REQ-029 pe_resp bits SHALL only be honoured in their own wait state; stray assertion elsewhere ignored.
REQ-030 start while busy SHALL be ignored; config inputs changing mid-job have no effect.

Reset
REQ-031 rst=1 at any clock edge, including mid-job: state IDLE, tap_cnt=0, watchdog=0, all outputs 0 next cycle; rst has priority over all transitions.

Verification
REQ-032 Conv, num_taps=3, bias_en=0, PE responds 4 cycles after each enable -> exactly 3 op transfers, 3 acc_wr_en, 1 add_en_2 phase, 1 of_rf_wr_en, done one cycle after WR.
REQ-033 Conv, num_taps=2, bias_en=1 -> 3 transfers; third asserts wt_rf_wr_en only; BADD shows add_in_sel=1, wt_in_sel=0; 3 acc_wr_en total.
REQ-034 Pool, num_taps=4 -> mult_en/add_en_1 never high, pe_out_sel=1, actn_in_sel=0, 4 transfers, done pulse.
REQ-035 start with num_taps=0 -> err pulse 1 cycle, busy stays 0; pe_resp[0] held low in MULT -> err exactly TMO cycles after MULT entry, return to IDLE.
REQ-036 rst pulsed during ADD -> next cycle all outputs 0, busy=0; fresh start then completes normally.
REQ-037 op_valid withheld 10 cycles in LOAD -> no err, op_ready held high, job resumes on transfer.
